hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline hazard unit. It adds a register scoreboard for multi-cycle (MUL/DIV) operations that retire out of order, a memory-wait freeze, and redirect flushes, alongside load-use, branch-compare and ALU forwarding. It sits beside the 5-stage pipeline and drives all stall, flush and forward-select controls.

---
 rtl/hazard_scoreboard_pkg.sv | 23 ++
 rtl/hazard_scoreboard_if.sv | 71 +++++++
 rtl/hazard_scoreboard_long_scoreboard.sv | 83 ++++++++
 rtl/hazard_scoreboard.sv | 139 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// ControlTypeDefs
// Shared pipeline-control types: the instruction class carried by each
// pipeline stage and the encodings of the ALU operand forward selects.
// ---------------------------------------------------------------------------
package ControlTypeDefs;

  typedef enum logic [2:0] {
    ALU    = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    BRANCH = 3'd3,
    JUMP   = 3'd4,
    UPPER  = 3'd5,
    SYSTEM = 3'd6
  } InstructionTypes;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;
  localparam logic [1:0] FWD_LONG = 2'd3;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundles every pipeline-facing signal of the hazard scoreboard.
//   master : pipeline side, drives the i* stage information, reads o* controls
//   slave  : hazard_scoreboard, reads the i* signals, drives o* controls
// Parameters: REG_AW register address width, CNT_W long-op counter width.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 2
);
  import ControlTypeDefs::*;

  InstructionTypes    iInstructionTypeD;
  InstructionTypes    iInstructionTypeE;
  InstructionTypes    iInstructionTypeM;
  logic               iJalrD;
  logic               iLongOpD;
  logic               iLongOpE;
  logic [REG_AW-1:0]  iSrcReg1D;
  logic [REG_AW-1:0]  iSrcReg2D;
  logic [REG_AW-1:0]  iDestRegD;
  logic [REG_AW-1:0]  iSrcReg1E;
  logic [REG_AW-1:0]  iSrcReg2E;
  logic [REG_AW-1:0]  iDestRegE;
  logic               iRegWriteEnE;
  logic               iRegWriteEnM;
  logic               iRegWriteEnW;
  logic [REG_AW-1:0]  iDestRegM;
  logic [REG_AW-1:0]  iDestRegW;
  logic               iLongWbValid;
  logic [REG_AW-1:0]  iLongWbReg;
  logic               iMemBusy;
  logic               iRedirectE;

  logic [1:0]         oForwardAluOp1E;
  logic [1:0]         oForwardAluOp2E;
  logic               oForwardCompOp1D;
  logic               oForwardCompOp2D;
  logic               oStallF;
  logic               oStallD;
  logic               oStallE;
  logic               oStallM;
  logic               oFlushD;
  logic               oFlushE;
  logic [CNT_W-1:0]   oLongCount;
  logic               oScoreErr;

  modport master (
    output iInstructionTypeD, iInstructionTypeE, iInstructionTypeM, iJalrD,
           iLongOpD, iLongOpE, iSrcReg1D, iSrcReg2D, iDestRegD,
           iSrcReg1E, iSrcReg2E, iDestRegE, iRegWriteEnE, iRegWriteEnM,
           iRegWriteEnW, iDestRegM, iDestRegW, iLongWbValid, iLongWbReg,
           iMemBusy, iRedirectE,
    input  oForwardAluOp1E, oForwardAluOp2E, oForwardCompOp1D,
           oForwardCompOp2D, oStallF, oStallD, oStallE, oStallM,
           oFlushD, oFlushE, oLongCount, oScoreErr
  );

  modport slave (
    input  iInstructionTypeD, iInstructionTypeE, iInstructionTypeM, iJalrD,
           iLongOpD, iLongOpE, iSrcReg1D, iSrcReg2D, iDestRegD,
           iSrcReg1E, iSrcReg2E, iDestRegE, iRegWriteEnE, iRegWriteEnM,
           iRegWriteEnW, iDestRegM, iDestRegW, iLongWbValid, iLongWbReg,
           iMemBusy, iRedirectE,
    output oForwardAluOp1E, oForwardAluOp2E, oForwardCompOp1D,
           oForwardCompOp2D, oStallF, oStallD, oStallE, oStallM,
           oFlushD, oFlushE, oLongCount, oScoreErr
  );

endinterface

// File: rtl/hazard_scoreboard_long_scoreboard.sv
// ---------------------------------------------------------------------------
// long_scoreboard
// Busy-bit register scoreboard for multi-cycle (MUL/DIV) results that retire
// out of order.
//   clk, rst       clock, asynchronous active-high reset
//   issue_valid    long op leaves E this cycle; issue_reg is its destination
//   retire_valid   long unit writes back this cycle; retire_reg is the target
//   rd_addr[2:0]   three lookup addresses, rd_busy[2:0] their busy bits
//   count          in-flight long operations
//   full/near_full count == MAX_LONG / count == MAX_LONG-1
//   err            sticky: retire of a non-busy register or counter underflow
// ---------------------------------------------------------------------------
module long_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_LONG = 2,
  parameter int CNT_W    = $clog2(MAX_LONG + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [REG_AW-1:0]      issue_reg,
  input  logic                   retire_valid,
  input  logic [REG_AW-1:0]      retire_reg,
  input  logic [2:0][REG_AW-1:0] rd_addr,
  output logic [2:0]             rd_busy,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   near_full,
  output logic                   err
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;
  logic                issue_fire;
  logic                retire_ok;
  logic                retire_bad;

  // x0 is hard-wired zero and never tracked.
  assign issue_fire = issue_valid && (issue_reg != '0);
  assign retire_ok  = retire_valid && busy_q[retire_reg] && (count_q != '0);
  assign retire_bad = retire_valid && !retire_ok;

  always_comb begin
    busy_d = busy_q;
    // Clear before set so a same-register issue and retire leaves it busy.
    if (retire_valid) busy_d[retire_reg] = 1'b0;
    if (issue_fire)   busy_d[issue_reg]  = 1'b1;
    busy_d[0] = 1'b0;

    count_d = count_q;
    case ({issue_fire, retire_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    err_d = err_q || retire_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) rd_busy[i] = busy_q[rd_addr[i]];
  end

  assign count     = count_q;
  assign full      = (count_q == CNT_W'(MAX_LONG));
  assign near_full = (count_q == CNT_W'(MAX_LONG - 1));
  assign err       = err_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Hazard unit for the 5-stage pipeline: long-op scoreboard stalls, load-use
// and branch-compare interlocks, ALU/comparator forwarding, memory-wait
// freeze and redirect flushes.
//   iClk, iRst  clock, asynchronous active-high reset
//   hz          hazard_scoreboard_if.slave: per-stage instruction info in,
//               stall/flush/forward controls, long-op count and error out
// Only the scoreboard holds state; every other output is combinational.
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import ControlTypeDefs::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_LONG = 2,
  parameter int CNT_W    = $clog2(MAX_LONG + 1)
) (
  input logic               iClk,
  input logic               iRst,
  hazard_scoreboard_if.slave hz
);

  // ALU operand source: M beats the long bus, which beats W.
  function automatic logic [1:0] alu_fwd(
    input logic [REG_AW-1:0] src,
    input logic              m_we,
    input logic [REG_AW-1:0] m_rd,
    input logic              l_v,
    input logic [REG_AW-1:0] l_rd,
    input logic              w_we,
    input logic [REG_AW-1:0] w_rd
  );
    if (src == '0)                  return FWD_RF;
    else if (m_we && (m_rd == src)) return FWD_MEM;
    else if (l_v && (l_rd == src))  return FWD_LONG;
    else if (w_we && (w_rd == src)) return FWD_WB;
    else                            return FWD_RF;
  endfunction

  logic [2:0]       sb_busy;
  logic [CNT_W-1:0] sb_count;
  logic             sb_full, sb_near_full, sb_err;
  logic             long_issue;

  // Memory wait freezes E, so a long op cannot leave E while it is held.
  assign long_issue = hz.iLongOpE && (hz.iDestRegE != '0) && !hz.iMemBusy;

  long_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW),
    .MAX_LONG (MAX_LONG),
    .CNT_W    (CNT_W)
  ) u_long_scoreboard (
    .clk          (iClk),
    .rst          (iRst),
    .issue_valid  (long_issue),
    .issue_reg    (hz.iDestRegE),
    .retire_valid (hz.iLongWbValid),
    .retire_reg   (hz.iLongWbReg),
    .rd_addr      ({hz.iDestRegD, hz.iSrcReg2D, hz.iSrcReg1D}),
    .rd_busy      (sb_busy),
    .count        (sb_count),
    .full         (sb_full),
    .near_full    (sb_near_full),
    .err          (sb_err)
  );

  logic wb_hit1, wb_hit2;
  logic sb_stall, load_use;
  logic is_br, cmp1_use, cmp2_use, e_wr, m_wr;
  logic cmp1_e, cmp2_e, cmp1_m, cmp2_m, br_stall;
  logic d_stall;

  always_comb begin
    // A result written back this cycle is visible to decode (write-first RF).
    wb_hit1  = hz.iLongWbValid && (hz.iLongWbReg == hz.iSrcReg1D);
    wb_hit2  = hz.iLongWbValid && (hz.iLongWbReg == hz.iSrcReg2D);
    sb_stall = (sb_busy[0] && !wb_hit1) || (sb_busy[1] && !wb_hit2) ||
               sb_busy[2] ||
               (hz.iLongOpD && (sb_full || (sb_near_full && long_issue)));

    load_use = (hz.iInstructionTypeE == LOAD) && (hz.iDestRegE != '0) &&
               ((hz.iDestRegE == hz.iSrcReg1D) || (hz.iDestRegE == hz.iSrcReg2D));

    // JALR compares only rs1; a branch compares both sources.
    is_br    = (hz.iInstructionTypeD == BRANCH) || hz.iJalrD;
    cmp1_use = is_br && (hz.iSrcReg1D != '0);
    cmp2_use = (hz.iInstructionTypeD == BRANCH) && (hz.iSrcReg2D != '0);
    e_wr     = hz.iRegWriteEnE && (hz.iDestRegE != '0);
    m_wr     = hz.iRegWriteEnM && (hz.iDestRegM != '0);
    cmp1_e   = cmp1_use && e_wr && (hz.iSrcReg1D == hz.iDestRegE);
    cmp2_e   = cmp2_use && e_wr && (hz.iSrcReg2D == hz.iDestRegE);
    cmp1_m   = cmp1_use && m_wr && (hz.iSrcReg1D == hz.iDestRegM);
    cmp2_m   = cmp2_use && m_wr && (hz.iSrcReg2D == hz.iDestRegM);
    br_stall = cmp1_e || cmp2_e ||
               ((hz.iInstructionTypeM == LOAD) && (cmp1_m || cmp2_m));

    d_stall  = sb_stall || load_use || br_stall;

    hz.oForwardCompOp1D = cmp1_m && !br_stall;
    hz.oForwardCompOp2D = cmp2_m && !br_stall;

    // Memory wait dominates; a redirect discards D so its stalls are moot.
    if (hz.iMemBusy) begin
      hz.oStallF = 1'b1;
      hz.oStallD = 1'b1;
      hz.oStallE = 1'b1;
      hz.oStallM = 1'b1;
      hz.oFlushD = 1'b0;
      hz.oFlushE = 1'b0;
    end else if (hz.iRedirectE) begin
      hz.oStallF = 1'b0;
      hz.oStallD = 1'b0;
      hz.oStallE = 1'b0;
      hz.oStallM = 1'b0;
      hz.oFlushD = 1'b1;
      hz.oFlushE = 1'b1;
    end else begin
      hz.oStallF = d_stall;
      hz.oStallD = d_stall;
      hz.oStallE = 1'b0;
      hz.oStallM = 1'b0;
      hz.oFlushD = 1'b0;
      hz.oFlushE = d_stall;
    end

    hz.oForwardAluOp1E = alu_fwd(hz.iSrcReg1E, hz.iRegWriteEnM, hz.iDestRegM,
                                 hz.iLongWbValid, hz.iLongWbReg,
                                 hz.iRegWriteEnW, hz.iDestRegW);
    hz.oForwardAluOp2E = alu_fwd(hz.iSrcReg2E, hz.iRegWriteEnM, hz.iDestRegM,
                                 hz.iLongWbValid, hz.iLongWbReg,
                                 hz.iRegWriteEnW, hz.iDestRegW);
  end

  assign hz.oLongCount = sb_count;
  assign hz.oScoreErr  = sb_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard with MAX_LONG = 2. Inputs change just
// after a rising edge and outputs are sampled 1 time unit later.
// Control word order: {StallF, StallD, StallE, StallM, FlushD, FlushE}.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
  import ControlTypeDefs::*;

  localparam logic [5:0] CTL_NONE   = 6'b000000;
  localparam logic [5:0] CTL_BUBBLE = 6'b110001;
  localparam logic [5:0] CTL_MEMW   = 6'b111100;
  localparam logic [5:0] CTL_REDIR  = 6'b000011;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  hazard_scoreboard_if #(.REG_AW(5), .CNT_W(2)) hz ();

  hazard_scoreboard #(
    .NUM_REGS (32),
    .REG_AW   (5),
    .MAX_LONG (2),
    .CNT_W    (2)
  ) dut (
    .iClk (clk),
    .iRst (rst),
    .hz   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ctl();
    return {hz.oStallF, hz.oStallD, hz.oStallE, hz.oStallM, hz.oFlushD, hz.oFlushE};
  endfunction

  task automatic idle();
    hz.iInstructionTypeD = ALU;
    hz.iInstructionTypeE = ALU;
    hz.iInstructionTypeM = ALU;
    hz.iJalrD       = 1'b0;
    hz.iLongOpD     = 1'b0;
    hz.iLongOpE     = 1'b0;
    hz.iSrcReg1D    = '0;
    hz.iSrcReg2D    = '0;
    hz.iDestRegD    = '0;
    hz.iSrcReg1E    = '0;
    hz.iSrcReg2E    = '0;
    hz.iDestRegE    = '0;
    hz.iRegWriteEnE = 1'b0;
    hz.iRegWriteEnM = 1'b0;
    hz.iRegWriteEnW = 1'b0;
    hz.iDestRegM    = '0;
    hz.iDestRegW    = '0;
    hz.iLongWbValid = 1'b0;
    hz.iLongWbReg   = '0;
    hz.iMemBusy     = 1'b0;
    hz.iRedirectE   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic retire(input logic [4:0] r);
    hz.iLongWbValid = 1'b1;
    hz.iLongWbReg   = r;
  endtask

  task automatic issue_e(input logic [4:0] r);
    hz.iLongOpE     = 1'b1;
    hz.iDestRegE    = r;
    hz.iRegWriteEnE = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(hz.oLongCount), 0);
    check("rst_err",   32'(hz.oScoreErr), 0);
    check("rst_ctl",   32'(ctl()), 32'(CTL_NONE));
    check("rst_fwd",   32'({hz.oForwardAluOp1E, hz.oForwardAluOp2E,
                            hz.oForwardCompOp1D, hz.oForwardCompOp2D}), 0);
    rst = 1'b0;
    step();

    // MUL x5 issues from E
    idle(); issue_e(5'd5); settle();
    check("mul_issue_ctl", 32'(ctl()), 32'(CTL_NONE));
    step();
    idle(); settle();
    check("mul_count", 32'(hz.oLongCount), 1);

    // ADD x6,x5,x1 waits in D on busy x5
    hz.iSrcReg1D = 5'd5; hz.iSrcReg2D = 5'd1; hz.iDestRegD = 5'd6; settle();
    check("raw_stall", 32'(ctl()), 32'(CTL_BUBBLE));
    step(); settle();
    check("raw_stall2", 32'(ctl()), 32'(CTL_BUBBLE));
    retire(5'd5); settle();
    check("raw_bypass", 32'(ctl()), 32'(CTL_NONE));
    step();
    idle(); settle();
    check("retire_count", 32'(hz.oLongCount), 0);
    check("retire_err",   32'(hz.oScoreErr), 0);

    // ADD in E: forward select priorities
    hz.iSrcReg1E = 5'd5; hz.iSrcReg2E = 5'd1; settle();
    check("fwd_rf", 32'(hz.oForwardAluOp1E), 0);
    retire(5'd5); settle();
    check("fwd_long", 32'(hz.oForwardAluOp1E), 3);
    hz.iRegWriteEnW = 1'b1; hz.iDestRegW = 5'd5; settle();
    check("fwd_long_over_w", 32'(hz.oForwardAluOp1E), 3);
    hz.iRegWriteEnM = 1'b1; hz.iDestRegM = 5'd5; settle();
    check("fwd_m_over_long", 32'(hz.oForwardAluOp1E), 1);
    idle();
    hz.iSrcReg1E = 5'd5; hz.iSrcReg2E = 5'd1;
    hz.iRegWriteEnW = 1'b1; hz.iDestRegW = 5'd1; settle();
    check("fwd_w_op2", 32'(hz.oForwardAluOp2E), 2);
    check("fwd_w_op1", 32'(hz.oForwardAluOp1E), 0);
    idle(); hz.iRegWriteEnM = 1'b1; settle();
    check("fwd_x0", 32'(hz.oForwardAluOp1E), 0);

    // Capacity: x3 and x4 in flight
    idle(); issue_e(5'd3); step();
    idle(); issue_e(5'd4); step();
    idle(); settle();
    check("cap_count2", 32'(hz.oLongCount), 2);
    hz.iLongOpD = 1'b1; hz.iSrcReg1D = 5'd10; hz.iSrcReg2D = 5'd11; hz.iDestRegD = 5'd12;
    settle();
    check("cap_full", 32'(ctl()), 32'(CTL_BUBBLE));
    retire(5'd3); settle();
    check("cap_full_retire", 32'(ctl()), 32'(CTL_BUBBLE));
    step();
    hz.iLongWbValid = 1'b0; settle();
    check("cap_count1", 32'(hz.oLongCount), 1);
    check("cap_room", 32'(ctl()), 32'(CTL_NONE));
    step();
    idle(); issue_e(5'd12);
    hz.iLongOpD = 1'b1; hz.iSrcReg1D = 5'd14; hz.iSrcReg2D = 5'd15; hz.iDestRegD = 5'd16;
    retire(5'd4); settle();
    check("cap_near_issue", 32'(ctl()), 32'(CTL_BUBBLE));
    step();
    idle(); settle();
    check("simul_count", 32'(hz.oLongCount), 1);
    retire(5'd12); step();
    idle(); settle();
    check("cap_drain_count", 32'(hz.oLongCount), 0);
    check("cap_drain_err",   32'(hz.oScoreErr), 0);

    // LW x7 then BEQ x7,x0
    hz.iInstructionTypeE = LOAD; hz.iDestRegE = 5'd7; hz.iRegWriteEnE = 1'b1;
    hz.iInstructionTypeD = BRANCH; hz.iSrcReg1D = 5'd7; settle();
    check("lu_br_e", 32'(ctl()), 32'(CTL_BUBBLE));
    check("lu_br_e_cmp", 32'(hz.oForwardCompOp1D), 0);
    step();
    hz.iInstructionTypeE = ALU; hz.iDestRegE = '0; hz.iRegWriteEnE = 1'b0;
    hz.iInstructionTypeM = LOAD; hz.iDestRegM = 5'd7; hz.iRegWriteEnM = 1'b1; settle();
    check("br_m_load", 32'(ctl()), 32'(CTL_BUBBLE));
    check("br_m_load_cmp", 32'(hz.oForwardCompOp1D), 0);
    step();
    hz.iInstructionTypeM = ALU; hz.iDestRegM = '0; hz.iRegWriteEnM = 1'b0;
    hz.iRegWriteEnW = 1'b1; hz.iDestRegW = 5'd7; settle();
    check("br_w", 32'(ctl()), 32'(CTL_NONE));
    check("br_w_cmp", 32'(hz.oForwardCompOp1D), 0);
    hz.iRegWriteEnM = 1'b1; hz.iDestRegM = 5'd7; settle();
    check("br_m_alu", 32'(ctl()), 32'(CTL_NONE));
    check("br_m_alu_cmp1", 32'(hz.oForwardCompOp1D), 1);
    hz.iSrcReg1D = '0; hz.iSrcReg2D = 5'd7; settle();
    check("br_m_alu_cmp2", 32'({hz.oForwardCompOp1D, hz.oForwardCompOp2D}), 1);
    idle();
    hz.iJalrD = 1'b1; hz.iSrcReg1D = 5'd2; hz.iSrcReg2D = 5'd9;
    hz.iRegWriteEnE = 1'b1; hz.iDestRegE = 5'd9; settle();
    check("jalr_rs2_ignored", 32'(ctl()), 32'(CTL_NONE));
    hz.iSrcReg1D = 5'd9; settle();
    check("jalr_e", 32'(ctl()), 32'(CTL_BUBBLE));
    hz.iRegWriteEnE = 1'b0; hz.iRegWriteEnM = 1'b1; hz.iDestRegM = 5'd9; settle();
    check("jalr_m_cmp", 32'({ctl(), hz.oForwardCompOp1D}), 32'({CTL_NONE, 1'b1}));

    // Memory wait over a load-use hazard
    idle();
    hz.iInstructionTypeE = LOAD; hz.iDestRegE = 5'd7; hz.iRegWriteEnE = 1'b1;
    hz.iSrcReg1D = 5'd7; hz.iMemBusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("memw_%0d", i), 32'(ctl()), 32'(CTL_MEMW));
      step();
    end
    hz.iMemBusy = 1'b0; settle();
    check("memw_release", 32'(ctl()), 32'(CTL_BUBBLE));
    idle(); issue_e(5'd13); hz.iMemBusy = 1'b1; hz.iRedirectE = 1'b1; settle();
    check("memw_redirect", 32'(ctl()), 32'(CTL_MEMW));
    step(); settle();
    check("memw_no_issue", 32'(hz.oLongCount), 0);
    hz.iMemBusy = 1'b0; hz.iRedirectE = 1'b0; step();
    idle(); settle();
    check("memw_issue_after", 32'(hz.oLongCount), 1);

    // Redirect over a RAW on busy x13, with a long op issuing from E
    hz.iSrcReg1D = 5'd13; settle();
    check("redir_pre", 32'(ctl()), 32'(CTL_BUBBLE));
    hz.iRedirectE = 1'b1; issue_e(5'd14); settle();
    check("redir_ctl", 32'(ctl()), 32'(CTL_REDIR));
    step();
    idle(); settle();
    check("redir_issue_count", 32'(hz.oLongCount), 2);
    retire(5'd13); step();
    idle(); retire(5'd14); step();
    idle(); settle();
    check("redir_drain", 32'(hz.oLongCount), 0);

    // Error path and asynchronous reset
    issue_e(5'd5); step();
    idle(); retire(5'd9); settle();
    check("err_pre", 32'(hz.oScoreErr), 0);
    step();
    idle(); settle();
    check("err_set", 32'(hz.oScoreErr), 1);
    check("err_count_hold", 32'(hz.oLongCount), 1);
    step(); settle();
    check("err_sticky", 32'(hz.oScoreErr), 1);
    #1 rst = 1'b1;
    #1;
    check("arst_count", 32'(hz.oLongCount), 0);
    check("arst_err",   32'(hz.oScoreErr), 0);
    rst = 1'b0;
    step();
    retire(5'd5); step();
    idle(); settle();
    check("late_retire_err",   32'(hz.oScoreErr), 1);
    check("late_retire_count", 32'(hz.oLongCount), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
